serial_deserializer: RTL and testbench

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/deser_pkg.sv | 10 +
 rtl/deser_out_buf.sv | 35 +++
 rtl/serial_deserializer.sv | 89 ++++++++
 tb/tb_serial_deserializer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// deser_pkg: shared FSM states and bit-order constants for serial_deserializer (PARITY state only with DESER_PARITY_EN)
package deser_pkg;
`ifdef DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;
endpackage

// File: rtl/deser_out_buf.sv
// deser_out_buf: holds the assembled word until consumed and flags dropped words
module deser_out_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             perr_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun <= load && out_valid && !out_ready;
      if (load && (!out_valid || out_ready)) begin
        data_out   <= word;
        out_valid  <= 1'b1;
        parity_err <= perr_in;
      end else if (out_ready) begin
        data_out   <= '0;
        out_valid  <= 1'b0;
        parity_err <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: framed serial-to-parallel converter with selectable bit order
// Optional even-parity bit after each word when DESER_PARITY_EN is defined.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             dir,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sh, sh_n, base, shifted, word;
  logic             dir_q, dir_n, start, load, perr;
  assign start = ser_valid && frame_start;
  assign dir_n = start ? dir : dir_q;
  // a new frame shifts from an empty register so no partial bits leak in
  assign base    = start ? '0 : sh;
  assign shifted = (dir_n == DIR_LSB_FIRST) ? {ser_in, base[WIDTH-1:1]} : {base[WIDTH-2:0], ser_in};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      dir_q <= DIR_MSB_FIRST;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      dir_q <= dir_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    load    = 1'b0;
    word    = shifted;
    perr    = 1'b0;
    if (start) begin
      state_n = SHIFT;
      cnt_n   = CW'(1);
      sh_n    = shifted;
    end else if (ser_valid && state == SHIFT) begin
      cnt_n = cnt + 1'b1;
      sh_n  = shifted;
      if (cnt == CW'(WIDTH - 1)) begin
`ifdef DESER_PARITY_EN
        state_n = PARITY;
`else
        state_n = IDLE;
        cnt_n   = '0;
        load    = 1'b1;
`endif
      end
    end
`ifdef DESER_PARITY_EN
    else if (ser_valid && state == PARITY) begin
      state_n = IDLE;
      cnt_n   = '0;
      load    = 1'b1;
      word    = sh;
      perr    = ^{sh, ser_in};
    end
`endif
  end
  deser_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .word      (word),
    .perr_in   (perr),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .overrun   (overrun),
    .parity_err(parity_err)
  );
endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: scoreboard bench for serial_deserializer (WIDTH=4)
module tb_serial_deserializer;
  logic       clk = 0, rst = 1, ser_in = 0, ser_valid = 0, frame_start = 0, dir = 0, out_ready = 1;
  logic [3:0] data_out;
  logic       out_valid, overrun, parity_err;
  int         checks = 0, errors = 0, ovr_seen = 0, ovr_exp = 0;
  logic       ovr_prev = 0;
  logic [4:0] exp_q[$];
`ifdef DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  serial_deserializer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .frame_start(frame_start),
    .dir(dir), .out_ready(out_ready), .data_out(data_out), .out_valid(out_valid),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic b, input logic fs, input logic d);
    ser_in = b; ser_valid = 1; frame_start = fs; dir = d;
    @(posedge clk); #1;
    ser_valid = 0; frame_start = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // seq[3] is sent first; exp is the hand-computed word
  task automatic frame(input logic [3:0] seq, input logic d, input logic d2, input int gap,
                       input logic [3:0] exp, input logic push, input logic inj, input logic set_rdy);
    if (push) exp_q.push_back({PAR ? inj : 1'b0, exp});
    for (int i = 3; i >= 0; i--) begin
      if (set_rdy && i == 0 && !PAR) out_ready = 1;
      send(seq[i], i == 3, (i == 3) ? d : d2);
      if (i > 0 || PAR) idle(gap);
    end
    if (PAR) begin
      if (set_rdy) out_ready = 1;
      send((^seq) ^ inj, 0, d2);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (overrun) begin
        ovr_seen++;
        chk("overrun_one_cycle", {31'b0, ovr_prev}, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h expected none", {parity_err, data_out});
        end else chk("word", {27'b0, parity_err, data_out}, {27'b0, exp_q.pop_front()});
      end
    end
    ovr_prev <= overrun;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 0;
    #2;
    chk("rst_data", {28'b0, data_out}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    chk("rst_perr", {31'b0, parity_err}, 0);
    @(posedge clk); #1 rst = 1;
    // msb-first 1,1,0,1 with latency check
    frame(4'b1101, 0, 0, 0, 4'b1101, 1, 0, 0);
    chk("lat_valid", {31'b0, out_valid}, 1);
    chk("lat_data", {28'b0, data_out}, 4'b1101);
    idle(2);
    // lsb-first frames, then dir toggle mid-frame
    frame(4'b1001, 1, 1, 0, 4'b1001, 1, 0, 0);
    frame(4'b1101, 1, 1, 0, 4'b1011, 1, 0, 0);
    idle(2);
    frame(4'b1101, 1, 0, 0, 4'b1011, 1, 0, 0);
    idle(2);
    // valid bits without frame_start in IDLE are ignored
    send(1, 0, 0); send(1, 0, 0);
    frame(4'b0100, 0, 0, 0, 4'b0100, 1, 0, 0);
    idle(2);
    // gaps of 3 cycles between bits
    frame(4'b1101, 0, 0, 3, 4'b1101, 1, 0, 0);
    idle(2);
    // overrun: second word dropped while first is held
    out_ready = 0;
    frame(4'b1101, 0, 0, 0, 4'b1101, 1, 0, 0);
    frame(4'b0110, 0, 0, 0, 4'b0110, 0, 0, 0);
    ovr_exp++;
    chk("ovr_pulse", {31'b0, overrun}, 1);
    chk("ovr_keep", {28'b0, data_out}, 4'b1101);
    idle(1);
    chk("ovr_clear", {31'b0, overrun}, 0);
    out_ready = 1;
    idle(2);
    // completion in the same cycle as consumption
    out_ready = 0;
    frame(4'b0011, 0, 0, 0, 4'b0011, 1, 0, 0);
    frame(4'b1010, 0, 0, 0, 4'b1010, 1, 0, 1);
    chk("swap_no_ovr", {31'b0, overrun}, 0);
    chk("swap_valid", {31'b0, out_valid}, 1);
    chk("swap_data", {28'b0, data_out}, 4'b1010);
    idle(2);
    // frame_start mid-frame restarts without overrun
    send(1, 1, 0); send(1, 0, 0);
    frame(4'b0110, 0, 0, 0, 4'b0110, 1, 0, 0);
    idle(2);
    // reset mid-frame discards partial word
    send(1, 1, 0); send(1, 0, 0);
    rst = 0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 0);
    chk("midrst_data", {28'b0, data_out}, 0);
    idle(1);
    rst = 1;
    frame(4'b1001, 0, 0, 0, 4'b1001, 1, 0, 0);
    // back-to-back frames
    frame(4'b1101, 0, 0, 0, 4'b1101, 1, 0, 0);
    frame(4'b0010, 0, 0, 0, 4'b0010, 1, 0, 0);
    idle(2);
`ifdef DESER_PARITY_EN
    frame(4'b1101, 0, 0, 0, 4'b1101, 1, 0, 0);
    frame(4'b1101, 0, 0, 0, 4'b1101, 1, 1, 0);
    idle(2);
`endif
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    chk("drain", exp_q.size(), 0);
    chk("overrun_count", ovr_seen, ovr_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
